// File: rtl/lut_eval_pkg.sv
// Shared types and constants for the serially reconfigurable LUT evaluator.
package lut_eval_pkg;

  // Controller modes: evaluating inputs, or shifting in a new truth table
  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Power-on truth table for the 3-input configuration
  localparam logic [7:0] DEFAULT_RESET_TT = 8'hA0;

endpackage

// File: rtl/lut_out_stage.sv
// Output register with valid/ready handshake for the LUT evaluator.
// The upstream side only opens while the controller is evaluating and no
// configuration bit is being presented.
module lut_out_stage (
  input  logic clk,
  input  logic rst,
  input  logic run_open,
  input  logic in_valid,
  input  logic lut_bit,
  input  logic out_ready,
  output logic in_ready,
  output logic accept,
  output logic out,
  output logic out_valid
);

  assign in_ready = run_open && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Capture a new result on accept, drop valid once consumed, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= lut_bit;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lut_eval_seq.sv
// Reconfigurable N_IN-input lookup table. A new table arrives serially
// (entry 0 first) into a shadow register and is committed in one step, so a
// half-loaded table is never used. Results leave through a registered
// valid/ready stage.
module lut_eval_seq
  import lut_eval_pkg::*;
#(
  parameter int                   N_IN     = 3,
  parameter logic [2**N_IN-1:0]   RESET_TT = DEFAULT_RESET_TT,
  parameter int                   CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out,
  output logic [CNT_W-1:0] eval_count
);

  localparam int TT_W = 2**N_IN;
  localparam int BC_W = $clog2(TT_W) + 1;
  localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(TT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state;
  logic [TT_W-1:0]   active_tt;
  logic [TT_W-1:0]   shadow;
  logic [TT_W-1:0]   shadow_next;
  logic [BC_W-1:0]   bit_cnt;
  logic              run_open;
  logic              lut_bit;
  logic              accept;

  // Bits enter at the top and walk down, so after a full load entry 0 sits at bit 0
  assign shadow_next = {cfg_bit, shadow[TT_W-1:1]};
  assign run_open    = (state == RUN) && !cfg_valid;
  assign lut_bit     = active_tt[in_bits];

  // Load controller: collect config bits, commit the full table atomically
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      active_tt <= RESET_TT;
      shadow    <= '0;
      bit_cnt   <= '0;
      cfg_done  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        RUN: begin
          if (cfg_valid) begin
            shadow  <= shadow_next;
            bit_cnt <= BC_W'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            shadow <= shadow_next;
            if (bit_cnt == LAST_IDX) begin
              active_tt <= shadow_next;
              bit_cnt   <= '0;
              cfg_done  <= 1'b1;
              state     <= RUN;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Count accepted evaluations, sticking at the maximum instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_count <= '0;
    end else if (accept && (eval_count != CNT_MAX)) begin
      eval_count <= eval_count + 1'b1;
    end
  end

  lut_out_stage u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .run_open  (run_open),
    .in_valid  (in_valid),
    .lut_bit   (lut_bit),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .accept    (accept),
    .out       (out),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_lut_eval_seq.sv
// Bench for lut_eval_seq: directed scenarios plus a randomized phase, all
// compared every cycle against a queue-based behavioural model. A second
// instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_lut_eval_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_bits = 3'd0;
  logic        out_ready = 1'b0;

  logic        cfg_done, in_ready, out_valid, out;
  logic [15:0] eval_count;
  logic        cfg_done4, in_ready4, out_valid4, out4;
  logic [3:0]  eval_count4;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [7:0] m_tt;
  bit         m_loading;
  bit         m_q[$];
  logic       m_out;
  logic       m_valid;
  logic       m_done;
  int         m_count;

  bit consumed[$];
  int done_pulses = 0;

  lut_eval_seq dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_done(cfg_done), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .eval_count(eval_count)
  );

  lut_eval_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_done(cfg_done4), .in_valid(in_valid), .in_ready(in_ready4),
    .in_bits(in_bits), .out_valid(out_valid4), .out_ready(out_ready),
    .out(out4), .eval_count(eval_count4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cv, input logic cb, input logic iv,
                               input logic [2:0] ib, input logic ordy);
    @(negedge clk);
    cfg_valid = cv;
    cfg_bit   = cb;
    in_valid  = iv;
    in_bits   = ib;
    out_ready = ordy;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_bit = 1'b0; in_valid = 1'b0; in_bits = 3'd0; out_ready = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out", out, 0);
    checkOutput("rst_cfg_done", cfg_done, 0);
    checkOutput("rst_eval_count", eval_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Per-cycle comparison against the model, then advance the model through the next edge
  initial begin
    bit acc;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        m_tt = 8'hA0; m_loading = 0; m_q.delete();
        m_out = 0; m_valid = 0; m_done = 0; m_count = 0;
      end
      exp_rdy = !m_loading && !cfg_valid && (!m_valid || out_ready);
      checkOutput("out_valid", out_valid, m_valid);
      if (m_valid || rst) checkOutput("out", out, m_out);
      checkOutput("cfg_done", cfg_done, m_done);
      checkOutput("in_ready", in_ready, exp_rdy);
      checkOutput("eval_count", eval_count, (m_count > 65535) ? 65535 : m_count);
      checkOutput("eval_count4", eval_count4, (m_count > 15) ? 15 : m_count);
      checkOutput("out_valid4", out_valid4, m_valid);
      if (m_valid) checkOutput("out4", out4, m_out);
      checkOutput("cfg_done4", cfg_done4, m_done);
      checkOutput("in_ready4", in_ready4, exp_rdy);
      if (cfg_done) done_pulses++;
      if (!rst) begin
        if (out_valid && out_ready) consumed.push_back(out);
        acc = in_valid && exp_rdy;
        m_done = 0;
        if (cfg_valid) begin
          m_q.push_back(cfg_bit);
          m_loading = 1;
          if (m_q.size() == 8) begin
            for (int i = 0; i < 8; i++) m_tt[i] = m_q[i];
            m_q.delete();
            m_loading = 0;
            m_done = 1;
          end
        end
        if (acc) begin
          m_out = m_tt[in_bits];
          m_valid = 1;
          m_count++;
        end else if (out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  initial begin
    int exp1[8] = '{0, 0, 0, 0, 0, 1, 0, 1};
    int exp2[8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    logic [7:0] t96;
    t96 = 8'h96;

    doReset();

    $display("[TB] scenario 1: reset table, back-to-back evaluation");
    consumed.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i), 1'b1);
      #2;
      checkOutput("s1_in_ready", in_ready, 1);
    end
    idle(2);
    checkOutput("s1_count_results", consumed.size(), 8);
    for (int i = 0; i < 8 && i < consumed.size(); i++)
      checkOutput($sformatf("s1_out%0d", i), consumed[i], exp1[i]);
    checkOutput("s1_eval_count", eval_count, 8);

    $display("[TB] scenario 2: serial load of 0x96 with gaps");
    done_pulses = 0;
    for (int b = 0; b < 8; b++) begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      applyStimulus(1'b1, t96[b], 1'b0, 3'd0, 1'b1);
    end
    idle(2);
    checkOutput("s2_done_pulses", done_pulses, 1);
    consumed.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 3'(i), 1'b1);
    idle(2);
    checkOutput("s2_count_results", consumed.size(), 8);
    for (int i = 0; i < 8 && i < consumed.size(); i++)
      checkOutput($sformatf("s2_out%0d", i), consumed[i], exp2[i]);

    $display("[TB] scenario 3: downstream stall");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
      #2;
      checkOutput("s3_in_ready", in_ready, 0);
      checkOutput("s3_out_valid", out_valid, 1);
      checkOutput("s3_out", out, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd6, 1'b1);
    #2;
    checkOutput("s3_release_ready", in_ready, 1);
    idle(2);

    $display("[TB] scenario 4/5: config priority, reset mid-load");
    done_pulses = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 1'b1);
    #2;
    checkOutput("s4_in_ready_cfg", in_ready, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 1'b1);
    #2;
    checkOutput("s4_in_ready_load", in_ready, 0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    doReset();
    checkOutput("s5_no_done", done_pulses, 0);
    consumed.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
    idle(2);
    checkOutput("s5_count_results", consumed.size(), 1);
    if (consumed.size() > 0) checkOutput("s5_out", consumed[0], 1);

    $display("[TB] random phase");
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) < 6));
      end
    end

    $display("[TB] scenario 6: counter saturation");
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 3'(i % 8), 1'b1);
    idle(2);
    checkOutput("s6_sat4", eval_count4, 15);
    checkOutput("s6_count16", eval_count, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lut_eval_seq.md
LUT_EVAL_SEQ -- requirements
Module: lut_eval_seq

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of logic inputs, legal range 1..8.
REQ-002 SHALL have parameter RESET_TT, default 8'hA0, width 2**N_IN: truth table loaded at reset. Bit i is the output for input vector i.
REQ-003 SHALL have parameter CNT_W, default 16: width of the evaluation counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a serial truth-table bit is present.
REQ-007 SHALL have port cfg_bit, input, 1 bit: truth-table bit, LSB (entry 0) first.
REQ-008 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when a new table is committed.
REQ-009 SHALL have port in_valid, input, 1 bit: in_bits is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts in_bits this cycle.
REQ-011 SHALL have port in_bits, input, N_IN bits: input vector, MSB = in1.
REQ-012 SHALL have port out_valid, output, 1 bit: out holds a result.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream consumes out.
REQ-014 SHALL have port out, output, 1 bit: registered function result.
REQ-015 SHALL have port eval_count, output, CNT_W bits: number of accepted evaluations, saturating.

Function
REQ-016 SHALL implement a two-state FSM: RUN and LOAD.
- Reset state: RUN.
- RUN -> LOAD: on the first cfg_valid=1 cycle; that cycle's cfg_bit is captured as entry 0.
- LOAD -> RUN: on the cycle the 2**N_IN-th bit is captured.
REQ-017 Config bits SHALL shift into a shadow register; cycles with cfg_valid=0 in LOAD are gaps and SHALL be held without loss.
REQ-018 On capture of the final bit, SHALL copy the shadow register atomically into the active table and pulse cfg_done for exactly one cycle. A partially loaded table SHALL never be used for evaluation.
REQ-019 SHALL drive in_ready = (state==RUN) && !cfg_valid && (!out_valid || out_ready).
- Configuration has priority over evaluation.
- No inputs are accepted in LOAD.
REQ-020 On accept (in_valid && in_ready), SHALL load out <= active_table[in_bits] and set out_valid=1 on the next edge (latency 1 cycle).
REQ-021 Back-to-back accepts SHALL sustain one result per cycle while out_ready=1.
REQ-022 When out_valid && out_ready and no accept occurs, SHALL clear out_valid on the next edge.
REQ-023 When out_valid && !out_ready, SHALL hold out and out_valid stable.
REQ-024 A pending result SHALL survive a LOAD and keep the value computed with the table that was active when it was accepted.
REQ-025 SHALL increment eval_count on each accept and saturate at 2**CNT_W-1 (no wrap).
REQ-026 The bit counter SHALL be sized $clog2(2**N_IN)+1 and SHALL clear on the LOAD -> RUN transition.

Reset
REQ-027 While rst=1, asynchronously and independent of clk, SHALL set:
- state = RUN
- active table = RESET_TT
- shadow register = 0
- bit counter = 0
- out = 0, out_valid = 0
- cfg_done = 0
- eval_count = 0
REQ-028 Reset asserted mid-LOAD SHALL discard the partial table; the active table reverts to RESET_TT.
REQ-029 After rst deasserts, the first accept SHALL be possible on the first clk edge.

Structure
REQ-030 The state enum (RUN, LOAD) and the default RESET_TT constant SHALL reside in shared package lut_eval_pkg.
REQ-031 The output register and valid/ready logic SHALL be a sub-module, lut_out_stage.
REQ-032 The table, the FSM and the counters SHALL remain in the top level.

Verification (N_IN=3 unless stated)
REQ-033 Scenario 1: after reset, apply in_bits 0..7 back-to-back with out_ready=1 -> out sequence 0,0,0,0,0,1,0,1, one result per cycle; eval_count=8.
REQ-034 Scenario 2: serially load 8'h96 (bits 0,1,1,0,1,0,0,1) with random gaps -> single cfg_done pulse on the eighth bit; in_bits 0..7 then yield 0,1,1,0,1,0,0,1.
REQ-035 Scenario 3: hold out_ready=0 with out_valid=1 for 5 cycles -> in_ready=0 and out stable; on release, the next input is accepted in the same cycle.
REQ-036 Scenario 4: cfg_valid and in_valid both asserted in RUN -> the input is not accepted and FSM enters LOAD.
REQ-037 Scenario 5: assert rst after 4 of 8 config bits -> cfg_done never pulses; in_bits=3'b101 then yields out=1 (RESET_TT).
REQ-038 Scenario 6: with CNT_W=4, perform 20 accepts -> eval_count saturates at 15.
